// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one Memory port between two cache controllers,
// with lock-held back-to-back ownership and a watchdog against a silent Memory.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          rdy0,
    output logic          rdy1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic [1:0]    grant,
    output logic          m_req,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_rdy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last, w_last_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_grant, w_grant_nxt;
    logic          r_m_req, w_m_req_nxt;
    logic          r_m_rw, w_m_rw_nxt;
    logic [AW-1:0] r_m_addr, w_m_addr_nxt;
    logic [DW-1:0] r_m_wdata, w_m_wdata_nxt;
    logic          r_rdy0, w_rdy0_nxt;
    logic          r_rdy1, w_rdy1_nxt;
    logic          r_err0, w_err0_nxt;
    logic          r_err1, w_err1_nxt;
    logic [DW-1:0] r_rdata0, w_rdata0_nxt;
    logic [DW-1:0] r_rdata1, w_rdata1_nxt;

    // Owner-side view of the current grantee; grant is one-hot, so bit 1 names the owner.
    logic          w_owner;
    logic          w_own_req;
    logic          w_own_lock;
    logic          w_own_rw;
    logic [AW-1:0] w_own_addr;
    logic [DW-1:0] w_own_wdata;

    assign w_owner     = r_grant[1];
    assign w_own_req   = w_owner ? req1   : req0;
    assign w_own_lock  = w_owner ? lock1  : lock0;
    assign w_own_rw    = w_owner ? rw1    : rw0;
    assign w_own_addr  = w_owner ? addr1  : addr0;
    assign w_own_wdata = w_owner ? wdata1 : wdata0;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    logic          w_pick1;
    logic          w_win_rw;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    assign w_pick1     = req1 & (~req0 | ~r_last);
    assign w_win_rw    = w_pick1 ? rw1    : rw0;
    assign w_win_addr  = w_pick1 ? addr1  : addr0;
    assign w_win_wdata = w_pick1 ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_grant   <= 2'b00;
            r_m_req   <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_rdy0    <= 1'b0;
            r_rdy1    <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_rw    <= w_m_rw_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_rdy0    <= w_rdy0_nxt;
            r_rdy1    <= w_rdy1_nxt;
            r_err0    <= w_err0_nxt;
            r_err1    <= w_err1_nxt;
            r_rdata0  <= w_rdata0_nxt;
            r_rdata1  <= w_rdata1_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_m_req_nxt   = r_m_req;
        w_m_rw_nxt    = r_m_rw;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_rdy0_nxt    = 1'b0;
        w_rdy1_nxt    = 1'b0;
        w_err0_nxt    = 1'b0;
        w_err1_nxt    = 1'b0;
        w_rdata0_nxt  = r_rdata0;
        w_rdata1_nxt  = r_rdata1;

        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant_nxt   = w_pick1 ? 2'b10 : 2'b01;
                    w_m_req_nxt   = 1'b1;
                    w_m_rw_nxt    = w_win_rw;
                    w_m_addr_nxt  = w_win_addr;
                    w_m_wdata_nxt = w_win_wdata;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = BUSY;
                end
            end
            BUSY: begin
                // The owner may retarget while waiting (writeback turning into fill).
                w_m_rw_nxt    = w_own_rw;
                w_m_addr_nxt  = w_own_addr;
                w_m_wdata_nxt = w_own_wdata;
                if (m_rdy) begin
                    w_rdy0_nxt = ~w_owner;
                    w_rdy1_nxt = w_owner;
                    if (!r_m_rw) begin
                        if (w_owner) w_rdata1_nxt = m_rdata;
                        else         w_rdata0_nxt = m_rdata;
                    end
                    w_m_req_nxt = 1'b0;
                    w_last_nxt  = w_owner;
                    w_state_nxt = DONE;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    w_rdy0_nxt  = ~w_owner;
                    w_rdy1_nxt  = w_owner;
                    w_err0_nxt  = ~w_owner;
                    w_err1_nxt  = w_owner;
                    w_m_req_nxt = 1'b0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            DONE: begin
                if (w_own_lock && w_own_req) begin
                    w_m_req_nxt   = 1'b1;
                    w_m_rw_nxt    = w_own_rw;
                    w_m_addr_nxt  = w_own_addr;
                    w_m_wdata_nxt = w_own_wdata;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = BUSY;
                end else begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rdy0    = r_rdy0;
    assign rdy1    = r_rdy1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign grant   = r_grant;
    assign m_req   = r_m_req;
    assign m_rw    = r_m_rw;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level
// model of two requesters, the round-robin rule and a bench-side memory.
module tb_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        req0, req1, rw0, rw1, lock0, lock1;
    logic [15:0] addr0, addr1, m_addr;
    logic [31:0] wdata0, wdata1, rdata0, rdata1, m_wdata, m_rdata;
    logic        rdy0, rdy1, err0, err1, m_req, m_rw, m_rdy;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [15:0]];

    mem_arbiter #(.AW(16), .DW(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .rdy0(rdy0), .rdy1(rdy1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .grant(grant),
        .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        m_rdy = 0; m_rdata = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({grant, m_req, m_rw} !== 4'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=0000", {grant, m_req, m_rw}); end
        total++; if ({rdy1, rdy0, err1, err0} !== 4'b0) begin bad++; $display("FAIL rst_pulses got=%b want=0000", {rdy1, rdy0, err1, err0}); end
        total++; if (m_addr !== 16'h0 || m_wdata !== 32'h0) begin bad++; $display("FAIL rst_bus got=%h/%h want=0/0", m_addr, m_wdata); end
        total++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h want=0/0", rdata0, rdata1); end
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; rw0 = 0; addr0 = 16'h0104;
        step();
        total++; if (grant !== 2'b01 || m_req !== 1'b1) begin bad++; $display("FAIL sr_grant got=%b/%b want=01/1", grant, m_req); end
        total++; if (m_addr !== 16'h0104 || m_rw !== 1'b0) begin bad++; $display("FAIL sr_bus got=%h/%b want=0104/0", m_addr, m_rw); end
        step(); step();
        m_rdy = 1; m_rdata = 32'hDEADBEEF;
        step();
        total++; if ({rdy1, rdy0} !== 2'b01 || m_req !== 1'b0) begin bad++; $display("FAIL sr_rdy got=%b/%b want=01/0", {rdy1, rdy0}, m_req); end
        total++; if (rdata0 !== 32'hDEADBEEF || rdata1 !== 32'h0) begin bad++; $display("FAIL sr_rdata got=%h/%h want=deadbeef/0", rdata0, rdata1); end
        m_rdy = 0; req0 = 0;
        step();
        total++; if (rdy0 !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL sr_after got=%b/%b want=0/00", rdy0, grant); end
        total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_hold got=%h want=deadbeef", rdata0); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        int n;
        do_reset();
        req0 = 1; req1 = 1; rw0 = 0; rw1 = 0; addr0 = 16'h0010; addr1 = 16'h0020;
        for (int g = 0; g < 4; g++) begin
            want = (g % 2 == 0) ? 2'b01 : 2'b10;
            step();
            n = 0;
            while (grant === 2'b00 && n < 8) begin step(); n++; end
            total++; if (grant !== want) begin bad++; $display("FAIL b2b_grant%0d got=%b want=%b", g, grant, want); end
            total++; if (m_addr !== (want == 2'b01 ? 16'h0010 : 16'h0020)) begin bad++; $display("FAIL b2b_addr%0d got=%h", g, m_addr); end
            step();
            m_rdy = 1; m_rdata = 32'h100 + g;
            step();
            total++; if ({rdy1, rdy0} !== want || m_req !== 1'b0) begin bad++; $display("FAIL b2b_rdy%0d got=%b/%b want=%b/0", g, {rdy1, rdy0}, m_req, want); end
            total++; if ((want == 2'b01 ? rdata0 : rdata1) !== 32'h100 + g) begin bad++; $display("FAIL b2b_data%0d got=%h/%h want=%h", g, rdata0, rdata1, 32'h100 + g); end
            m_rdy = 0;
            step();
            total++; if ({rdy1, rdy0} !== 2'b00 || m_req !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL b2b_gap%0d got=%b/%b/%b want=00/0/00", g, {rdy1, rdy0}, m_req, grant); end
        end
        req0 = 0; req1 = 0;
        step(); step();
    endtask

    task automatic test_locked();
        do_reset();
        req1 = 1; rw1 = 0; addr1 = 16'h0300;
        req0 = 1; lock0 = 1; rw0 = 1; addr0 = 16'h0A00; wdata0 = 32'h11223344;
        step();
        total++; if (grant !== 2'b01 || m_rw !== 1'b1 || m_addr !== 16'h0A00 || m_wdata !== 32'h11223344) begin bad++; $display("FAIL lk_wr got=%b/%b/%h/%h want=01/1/0a00/11223344", grant, m_rw, m_addr, m_wdata); end
        step();
        m_rdy = 1;
        step();
        total++; if (rdy0 !== 1'b1 || rdata0 !== 32'h0 || grant !== 2'b01) begin bad++; $display("FAIL lk_wrdone got=%b/%h/%b want=1/0/01", rdy0, rdata0, grant); end
        m_rdy = 0; addr0 = 16'h1200; rw0 = 0;
        step();
        total++; if (grant !== 2'b01 || m_req !== 1'b1 || m_addr !== 16'h1200 || m_rw !== 1'b0) begin bad++; $display("FAIL lk_reissue got=%b/%b/%h/%b want=01/1/1200/0", grant, m_req, m_addr, m_rw); end
        lock0 = 0;
        step();
        m_rdy = 1; m_rdata = 32'hCAFEF00D;
        step();
        total++; if (rdy0 !== 1'b1 || rdata0 !== 32'hCAFEF00D) begin bad++; $display("FAIL lk_fill got=%b/%h want=1/cafef00d", rdy0, rdata0); end
        m_rdy = 0; req0 = 0;
        step();
        total++; if (grant !== 2'b00 || m_req !== 1'b0) begin bad++; $display("FAIL lk_release got=%b/%b want=00/0", grant, m_req); end
        step();
        total++; if (grant !== 2'b10 || m_addr !== 16'h0300) begin bad++; $display("FAIL lk_next got=%b/%h want=10/0300", grant, m_addr); end
        m_rdy = 1;
        step();
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL lk_rdy1 got=%b want=1", rdy1); end
        m_rdy = 0; req1 = 0;
        step(); step();
    endtask

    task automatic test_timeout();
        do_reset();
        req1 = 1; rw1 = 0; addr1 = 16'h0777;
        step();
        m_rdy = 1; m_rdata = 32'h5A5A0001;
        step();
        m_rdy = 0;
        step(); step();
        total++; if (grant !== 2'b10 || rdata1 !== 32'h5A5A0001) begin bad++; $display("FAIL to_regrant got=%b/%h want=10/5a5a0001", grant, rdata1); end
        for (int c = 1; c <= 4; c++) begin
            step();
            total++; if ({rdy1, err1} !== 2'b00 || m_req !== 1'b1) begin bad++; $display("FAIL to_wait%0d got=%b/%b want=00/1", c, {rdy1, err1}, m_req); end
        end
        step();
        total++; if ({rdy1, err1} !== 2'b11 || {rdy0, err0} !== 2'b00 || m_req !== 1'b0) begin bad++; $display("FAIL to_abort got=%b/%b/%b want=11/00/0", {rdy1, err1}, {rdy0, err0}, m_req); end
        total++; if (rdata1 !== 32'h5A5A0001) begin bad++; $display("FAIL to_rdata got=%h want=5a5a0001", rdata1); end
        req1 = 0;
        step();
        total++; if ({rdy1, err1} !== 2'b00 || grant !== 2'b00) begin bad++; $display("FAIL to_after got=%b/%b want=00/00", {rdy1, err1}, grant); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        req0 = 1; rw0 = 0; addr0 = 16'h0040;
        step();
        m_rdy = 1; m_rdata = 32'h00000040;
        step();
        m_rdy = 0;
        step(); step();
        total++; if (grant !== 2'b01 || rdata0 !== 32'h00000040) begin bad++; $display("FAIL rm_pending got=%b/%h want=01/00000040", grant, rdata0); end
        step();
        rst = 1;
        step();
        total++; if ({grant, m_req, m_rw, rdy1, rdy0, err1, err0} !== 8'b0 || m_addr !== 16'h0 || rdata0 !== 32'h0) begin bad++; $display("FAIL rm_zero got=%b/%h/%h", {grant, m_req, m_rw, rdy1, rdy0, err1, err0}, m_addr, rdata0); end
        rst = 0; req0 = 0; m_rdy = 1; m_rdata = 32'hFFFF0000;
        step();
        total++; if (rdy0 !== 1'b0 || rdata0 !== 32'h0 || grant !== 2'b00 || m_req !== 1'b0) begin bad++; $display("FAIL rm_stray got=%b/%h/%b/%b want=0/0/00/0", rdy0, rdata0, grant, m_req); end
        m_rdy = 0; req0 = 1; req1 = 1;
        step();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL rm_tie got=%b want=01", grant); end
        req0 = 0; req1 = 0;
        do_reset();
    endtask

    task automatic test_withdraw();
        do_reset();
        req1 = 1; rw1 = 0; addr1 = 16'h0222;
        step();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL wd_grant got=%b want=10", grant); end
        req1 = 0;
        step(); step();
        m_rdy = 1; m_rdata = 32'h0BADF00D;
        step();
        total++; if (rdy1 !== 1'b1 || rdata1 !== 32'h0BADF00D) begin bad++; $display("FAIL wd_rdy got=%b/%h want=1/0badf00d", rdy1, rdata1); end
        m_rdy = 0;
        step();
        total++; if (grant !== 2'b00 || m_req !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b/%b want=00/0", grant, m_req); end
        step();
        total++; if (grant !== 2'b00 || rdy1 !== 1'b0) begin bad++; $display("FAIL wd_stay got=%b/%b want=00/0", grant, rdy1); end
    endtask

    // Random traffic: the model tracks only whether the bus is free, in flight or in its
    // bubble cycle, who owns it, who was served last and what memory should hold.
    task automatic test_random();
        logic        rq [2];
        logic        w [2];
        logic [15:0] a [2];
        logic [31:0] d [2];
        logic [31:0] exp_rd [2];
        int          gap [2];
        int          phase, lat, owner, exp_last, win;
        logic        pr0, pr1, pm, resp_read;
        logic [31:0] resp_data;
        logic [1:0]  oh;
        do_reset();
        phase = 0; lat = 0; owner = 0; exp_last = 1; resp_read = 0; resp_data = '0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0; exp_rd[i] = '0; gap[i] = $urandom_range(0, 2);
        end
        for (int n = 0; n < 400; n++) begin
            pr0 = req0; pr1 = req1; pm = m_rdy;
            step();
            oh = (owner == 1) ? 2'b10 : 2'b01;
            if (phase == 0) begin
                if (pr0 || pr1) begin
                    win = (pr0 && (!pr1 || exp_last == 1)) ? 0 : 1;
                    owner = win;
                    oh = (win == 1) ? 2'b10 : 2'b01;
                    total++; if (grant !== oh || m_req !== 1'b1) begin bad++; $display("FAIL rnd_grant n=%0d got=%b/%b want=%b/1", n, grant, m_req, oh); end
                    total++; if (m_addr !== a[win] || m_rw !== w[win]) begin bad++; $display("FAIL rnd_issue n=%0d got=%h/%b want=%h/%b", n, m_addr, m_rw, a[win], w[win]); end
                    phase = 1; lat = $urandom_range(0, 3);
                end else begin
                    total++; if (grant !== 2'b00 || m_req !== 1'b0) begin bad++; $display("FAIL rnd_idle n=%0d got=%b/%b want=00/0", n, grant, m_req); end
                end
                total++; if ({rdy1, rdy0, err1, err0} !== 4'b0) begin bad++; $display("FAIL rnd_stray n=%0d got=%b want=0000", n, {rdy1, rdy0, err1, err0}); end
            end else if (phase == 1) begin
                if (pm) begin
                    total++; if ({rdy1, rdy0} !== oh || {err1, err0} !== 2'b00) begin bad++; $display("FAIL rnd_done n=%0d got=%b/%b want=%b/00", n, {rdy1, rdy0}, {err1, err0}, oh); end
                    if (resp_read) exp_rd[owner] = resp_data;
                    total++; if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h/%h want=%h/%h", n, rdata0, rdata1, exp_rd[0], exp_rd[1]); end
                    total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rnd_mreq_low n=%0d got=%b want=0", n, m_req); end
                    exp_last = owner; phase = 2; rq[owner] = 0; gap[owner] = $urandom_range(0, 3);
                end else begin
                    total++; if (grant !== oh || m_req !== 1'b1 || {rdy1, rdy0} !== 2'b00) begin bad++; $display("FAIL rnd_wait n=%0d got=%b/%b/%b want=%b/1/00", n, grant, m_req, {rdy1, rdy0}, oh); end
                end
            end else begin
                total++; if (grant !== 2'b00 || m_req !== 1'b0 || {rdy1, rdy0} !== 2'b00) begin bad++; $display("FAIL rnd_bubble n=%0d got=%b/%b/%b want=00/0/00", n, grant, m_req, {rdy1, rdy0}); end
                phase = 0;
            end
            if (phase == 1 && lat == 0) begin
                total++; if (m_addr !== a[owner] || m_rw !== w[owner] || (w[owner] && m_wdata !== d[owner])) begin bad++; $display("FAIL rnd_bus n=%0d got=%h/%b/%h want=%h/%b/%h", n, m_addr, m_rw, m_wdata, a[owner], w[owner], d[owner]); end
                m_rdy = 1;
                resp_read = !w[owner];
                if (w[owner]) begin
                    mem[a[owner]] = d[owner];
                    m_rdata = $urandom;
                end else begin
                    resp_data = mem.exists(a[owner]) ? mem[a[owner]] : {16'hA5A5, a[owner]};
                    m_rdata = resp_data;
                end
            end else begin
                if (phase == 1) lat--;
                m_rdy = (phase != 1) && ($urandom_range(0, 3) == 0);
                m_rdata = $urandom;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rq[i]) begin
                    if (gap[i] == 0) begin
                        rq[i] = 1; w[i] = 1'($urandom_range(0, 1));
                        a[i] = 16'($urandom_range(0, 7)); d[i] = $urandom;
                    end else begin
                        gap[i]--;
                    end
                end
            end
            req0 = rq[0]; rw0 = w[0]; addr0 = a[0]; wdata0 = d[0];
            req1 = rq[1]; rw1 = w[1]; addr1 = a[1]; wdata1 = d[1];
        end
        m_rdy = 0; req0 = 0; req1 = 0;
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_locked();
        test_timeout();
        test_reset_mid_busy();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation did not finish in time");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single word-wide `Memory` instance between two cache controllers (e.g. an instruction-side and a data-side two-way cache). Each controller keeps its existing memory-side request/ready handshake unchanged. The arbiter grants them round-robin, forwards one transaction at a time to `Memory`, and routes ready and read data back to the granted side. A lock input keeps a writeback and its refill as one uninterrupted sequence, and a watchdog releases the bus if `Memory` never answers.

## Interface
Parameters:
- `AW`, 16: memory address width.
- `DW`, 32: memory word width.
- `TIMEOUT`, 255: maximum cycles to wait for `m_rdy` before abort; must be ≥ 1. Counter width is `$clog2(TIMEOUT+1)`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0`, `req1`  in  1: transaction request from requester 0 / 1; held until the matching `rdy`.
- `rw0`, `rw1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  AW: word address.
- `wdata0`, `wdata1`  in  DW: write data.
- `lock0`, `lock1`  in  1: keep the grant after the current transaction completes.
- `rdy0`, `rdy1`  out  1: one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW: read data; valid while `rdyN` = 1 and held until that requester's next completion.
- `err0`, `err1`  out  1: one-cycle pulse on watchdog abort; coincides with `rdyN`.
- `grant`  out  2: one-hot current owner; 00 when idle.
- `m_req`  out  1: request to `Memory`.
- `m_rw`  out  1: read/write to `Memory`.
- `m_addr`  out  AW: address to `Memory`.
- `m_wdata`  out  DW: write data to `Memory`.
- `m_rdata`  in  DW: read data from `Memory`.
- `m_rdy`  in  1: `Memory` done.

## Operation
- States: `IDLE`, `BUSY`, `DONE`.
- **IDLE:**
  - Only one requester has `req` = 1: grant it.
  - Both have `req` = 1: grant the one that is not `last` (`last` = most recent grantee).
  - On grant, register `m_addr`, `m_rw` and `m_wdata` from the winner, set `m_req` = 1, set the one-hot `grant`, clear the watchdog counter, go to `BUSY`.
- **BUSY:**
  - `m_req` stays at 1.
  - Memory-side outputs are recaptured from the owner every cycle, so the owner may change address during wait, as the cache does when going from writeback to fill.
  - The counter increments each cycle.
  - On `m_rdy` = 1:
    - pulse `rdyN`;
    - on a read, capture `m_rdata` into `rdataN`;
    - set `m_req` = 0;
    - set `last` = owner;
    - go to `DONE`.
  - Counter reaching `TIMEOUT` with no `m_rdy`: pulse `rdyN` and `errN`, keep `rdataN` unchanged, set `m_req` = 0, go to `DONE`.
- **DONE** (one bubble cycle, so `Memory` sees `m_req` low):
  - `lockN` = 1 and `reqN` = 1 for the owner: re-issue to the same owner (`BUSY`, `grant` unchanged).
  - Otherwise: `grant` = 00, go to `IDLE`.
- `m_rdy` arriving in `IDLE` or `DONE` is ignored.
- An owner dropping `req` in `BUSY` does not abort; the transaction completes and `rdy` still pulses.
- Without lock, each requester gets one transaction per arbitration, so strict alternation under continuous contention.
- Reset values:
  - `grant` = 00, `m_req` = 0, `m_rw` = 0, `m_addr` = 0, `m_wdata` = 0.
  - `rdy0/1` = 0, `err0/1` = 0, `rdata0/1` = 0.
  - state `IDLE`, `last` = 1 (requester 0 wins the first tie), counter = 0.
- Reset mid-transaction: abandoned at the next edge; no `rdy` or `err` is issued.

## Timing
- All outputs registered.
- `req` sampled high at edge k in `IDLE` → `m_req`, `grant`, `m_addr` valid after edge k.
- `m_rdy` sampled at edge j → `rdyN` = 1 and `rdataN` valid after edge j, `m_req` = 0.
- Next grant is visible after edge j+2 (`DONE`, then `IDLE`).
- Locked re-issue: `m_req` high again after edge j+1.
- Abort: `rdyN`/`errN` are asserted after the edge at which the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after grant.

## Test plan
- **Single read:** reset; `req0` = 1, `rw0` = 0, `addr0` = 0x0104. Memory answers `m_rdy` 3 cycles later with 0xDEADBEEF.
  → `m_addr` = 0x0104, `grant` = 01, `rdy0` pulses once, `rdata0` = 0xDEADBEEF, `rdata1` = 0.
- **Simultaneous requests after reset:** `req0` = `req1` = 1, both held.
  → grant order 01, 10, 01, 10; each `rdyN` exactly once per grant; `m_req` low for ≥1 cycle between grants.
- **Locked writeback + fill:**
  - Stimulus: `req0` + `lock0` = 1 with write to 0x0A00 (`wdata0` = 0x11223344); after `rdy0`, `lock0` drops and `req0` reissues a read of 0x1200. `req1` is held high throughout.
  - Required: `Memory` sees write 0x0A00 then read 0x1200, then requester 1; `grant` stays 01 across `DONE`.
- **Timeout:** `TIMEOUT` = 4, `req1` = 1, `m_rdy` tied 0.
  → `rdy1` = `err1` = 1 for one cycle 5 cycles after grant, `rdata1` unchanged, then `grant` = 00.
- **Reset mid-BUSY:** assert `rst` during a pending read on requester 0, then answer `m_rdy`.
  → all outputs 0 after the reset edge, no `rdy0`, stray `m_rdy` ignored; the next tie goes to requester 0.
- **Request withdrawn:** `req1` drops during `BUSY`.
  → transaction completes, `rdy1` pulses, arbiter returns to `IDLE`, `grant` = 00.
